// File: rtl/gfx_pkg.sv
// Shared constants and types for the text-cell display controller.
package gfx_pkg;

    localparam int CELL = 16;
    localparam int COLS = 16;
    localparam int ROWS = 2;

    localparam logic [6:0] CH_SPACE = 7'h20;
    localparam logic [6:0] CH_BS    = 7'h08;
    localparam logic [6:0] CH_LF    = 7'h0A;
    localparam logic [6:0] CH_FF    = 7'h0C;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    function automatic logic is_printable(input logic [6:0] code);
        return (code >= 7'h20) && (code <= 7'h7E);
    endfunction

endpackage

// File: rtl/text_buf.sv
// Character cell store: one synchronous write port, one synchronous read-before-write port.
module text_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [6:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [6:0]    rdata_o
);

    // NOTE: storage has no reset so it maps onto block RAM; the owner sweeps it clean after reset.
    logic [6:0] mem_q [DEPTH];

    // NOTE: non-blocking assignments make the same-cycle read return the pre-write contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/text_cell_ctrl.sv
// Text-mode cell controller: accepts typed characters/editing codes into a cell buffer
// and serves glyph codes to the renderer with one cycle of latency.
module text_cell_ctrl
    import gfx_pkg::*;
#(
    parameter int COLS = gfx_pkg::COLS,
    parameter int ROWS = gfx_pkg::ROWS,
    parameter int CELL = gfx_pkg::CELL
) (
    input  logic        pix_clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [6:0]  wr_char,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic [6:0]  character,
    output logic        full,
    output logic        busy
);

    localparam int NCELL   = COLS * ROWS;
    localparam int CUR_W   = $clog2(NCELL + 1);
    localparam int IDX_W   = $clog2(NCELL);
    localparam int CELL_SH = $clog2(CELL);
    localparam int COLS_SH = $clog2(COLS);

    localparam logic [CUR_W-1:0] CUR_FULL = CUR_W'(NCELL);
    localparam logic [CUR_W-1:0] LAST_ROW = CUR_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCELL - 1);
    localparam logic [12:0]      X_LIM    = 13'(COLS * CELL);
    localparam logic [12:0]      Y_LIM    = 13'(ROWS * CELL);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic [CUR_W-1:0]   cursor_q, cursor_d;
    logic [CUR_W-1:0]   cur_row;
    logic               vis_q;
    logic [11:0]        o_x_q, o_y_q;

    logic               buf_we;
    logic [IDX_W-1:0]   buf_waddr;
    logic [6:0]         buf_wdata;
    logic [IDX_W-1:0]   buf_raddr;
    logic [6:0]         buf_rdata;

    logic [11:0]        pix_col, pix_row, pix_idx;
    logic               in_area;

    assign cur_row = cursor_q >> COLS_SH;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        cursor_d  = cursor_q;
        buf_we    = 1'b0;
        buf_waddr = cursor_q[IDX_W-1:0];
        buf_wdata = CH_SPACE;

        unique case (state_q)
            ST_CLEAR: begin
                buf_we    = 1'b1;
                buf_waddr = sweep_q;
                if (sweep_q == IDX_LAST) begin
                    state_d  = ST_IDLE;
                    sweep_d  = '0;
                    cursor_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (wr_valid) begin
                    if (is_printable(wr_char)) begin
                        if (cursor_q != CUR_FULL) begin
                            buf_we    = 1'b1;
                            buf_wdata = wr_char;
                            cursor_d  = cursor_q + 1'b1;
                        end
                    end else begin
                        case (wr_char)
                            CH_BS: begin
                                if (cursor_q != '0) begin
                                    cursor_d  = cursor_q - 1'b1;
                                    buf_we    = 1'b1;
                                    buf_waddr = cursor_d[IDX_W-1:0];
                                end
                            end
                            // A full cursor sits past the last row, so newline is a no-op there too.
                            CH_LF: begin
                                if (cur_row < LAST_ROW) begin
                                    cursor_d = (cur_row + 1'b1) << COLS_SH;
                                end
                            end
                            CH_FF: begin
                                state_d = ST_CLEAR;
                                sweep_d = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign pix_col   = i_x >> CELL_SH;
    assign pix_row   = i_y >> CELL_SH;
    assign pix_idx   = (pix_row << COLS_SH) + pix_col;
    assign buf_raddr = pix_idx[IDX_W-1:0];
    assign in_area   = ({1'b0, i_x} < X_LIM) && ({1'b0, i_y} < Y_LIM);

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_CLEAR;
            sweep_q  <= '0;
            cursor_q <= '0;
            vis_q    <= 1'b0;
            o_x_q    <= '0;
            o_y_q    <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            cursor_q <= cursor_d;
            vis_q    <= in_area && (state_q == ST_IDLE);
            o_x_q    <= i_x;
            o_y_q    <= i_y;
        end
    end

    text_buf #(
        .DEPTH (NCELL),
        .AW    (IDX_W)
    ) u_buf (
        .clk_i   (pix_clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (buf_wdata),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    // The glyph register is qualified by a visibility flag captured alongside o_x/o_y.
    assign character = (vis_q && !busy) ? buf_rdata : 7'h00;
    assign o_x       = o_x_q;
    assign o_y       = o_y_q;
    assign wr_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CLEAR);
    assign full      = (cursor_q == CUR_FULL);

endmodule

// File: doc/text_cell_ctrl.md
TEXT_CELL_CTRL -- requirements
Module: text_cell_ctrl

Interface
REQ-001 Parameter COLS, default 16: text columns per row.
REQ-002 Parameter ROWS, default 2: text rows; row 0 holds the expression, row 1 the result.
REQ-003 Parameter CELL, default 16: cell size in pixels, square, power of two.
REQ-004 Port pix_clk, input, 1 bit: the single clock.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port wr_valid, input, 1 bit: the writer offers a command.
REQ-007 Port wr_ready, output, 1 bit: the block accepts the offered command.
REQ-008 Port wr_char, input, 7 bits: the ASCII command or character.
REQ-009 Port i_x and port i_y, input, 12 bits each: current pixel coordinate from video timing.
REQ-010 Port o_x and port o_y, output, 12 bits each: i_x and i_y delayed to align with character.
REQ-011 Port character, output, 7 bits: glyph code for the glyph renderer.
REQ-012 Port full, output, 1 bit: the cursor is at COLS*ROWS.
REQ-013 Port busy, output, 1 bit: a clear sweep is in progress.

Function
REQ-014 A command transfers on any rising pix_clk edge with wr_valid=1 and wr_ready=1.
REQ-015 wr_ready SHALL equal 1 exactly when the state is IDLE.
REQ-016 States: IDLE and CLEAR.
REQ-017 CLEAR writes 0x20 to one cell per cycle, indices 0 to COLS*ROWS-1, then goes to IDLE with cursor=0, so the sweep lasts COLS*ROWS cycles.
REQ-018 A printable code (0x20..0x7E) accepted with cursor<COLS*ROWS writes the code to cell[cursor] and increments the cursor.
REQ-019 A printable code accepted with cursor=COLS*ROWS is discarded; the cursor and the buffer are unchanged.
REQ-020 Code 0x08 (backspace) with cursor>0 decrements the cursor and writes 0x20 to the new cursor cell.
REQ-021 Code 0x08 with cursor=0 is a no-op.
REQ-022 Code 0x0A (newline) sets the cursor to the start of the next row; if the cursor is already in the last row, the code is a no-op.
REQ-023 Code 0x0C (clear) enters CLEAR on the next cycle.
REQ-024 Any other code is accepted and ignored.
REQ-025 The cursor SHALL be $clog2(COLS*ROWS+1) bits wide and SHALL never exceed COLS*ROWS.
REQ-026 Cell index = (i_y/CELL)*COLS + (i_x/CELL), computed by shifts only.
REQ-027 A pixel is inside the text area when i_x<COLS*CELL and i_y<ROWS*CELL.
REQ-028 Read latency is exactly 1 cycle: character, o_x and o_y are registered together from the i_x and i_y of the previous cycle.
REQ-029 character = 0x00 for a pixel outside the text area, or while busy.
REQ-030 A write and a display read of the same cell in the same cycle returns the old value (read-before-write).
REQ-031 full = 1 exactly when cursor=COLS*ROWS.
REQ-032 busy = 1 exactly when the state is CLEAR.

Reset
REQ-033 On rst assertion: state=CLEAR, sweep index=0, cursor=0, character=0x00, o_x=0, o_y=0, wr_ready=0, busy=1, full=0.
REQ-034 The buffer cells are not reset; the post-reset CLEAR sweep initialises them.
REQ-035 Asserting rst mid-sweep restarts the sweep at index 0.
REQ-036 Asserting rst with a handshake pending drops the command.

Structure
REQ-037 Shared package gfx_pkg holds CELL, COLS, ROWS, the codes CH_SPACE, CH_BS, CH_LF and CH_FF, and the state enum.
REQ-038 One sub-module, text_buf, implements the buffer: COLS*ROWS x 7-bit, one synchronous write port, one synchronous read port, read-before-write.

Verification
REQ-039 Scenario reset: release rst, then wait 32 cycles -> busy=1 for 32 cycles, then wr_ready=1; all cells read 0x20; character=0x00 while busy.
REQ-040 Scenario write and display: write "1","+","2" -> cells 0..2 = 0x31, 0x2B, 0x32, cursor=3; drive i_x=20, i_y=5 -> next cycle character=0x2B, o_x=20, o_y=5.
REQ-041 Scenario full: write 33 printable codes -> full=1 after the 32nd; the 33rd is accepted, the buffer is unchanged, cursor=32.
REQ-042 Scenario backspace and newline: backspace at cursor=0 -> no change; write "7", send 0x0A -> cursor=16; send 0x0A again -> cursor=16; backspace -> cursor=15, cell 15=0x20.
REQ-043 Scenario out of area and collision: i_x=256 or i_y=32 -> character=0x00; write cell 4 while displaying cell 4 in the same cycle -> old value shown, new value on the next read.
REQ-044 Scenario clear and reset mid-sweep: send 0x0C during random wr_valid traffic -> wr_ready=0 for exactly 32 cycles; assert rst at sweep index 10 -> the sweep restarts and completes 32 cycles after rst deasserts.
